// File: rtl/updown_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | updown_pulse_gen: turns raw up/down/load buttons into clean pulses.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module updown_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_PERIOD   = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_load,
   input  logic repeat_en,
   output logic up_pulse,
   output logic down_pulse,
   output logic load_pulse,
   output logic held
);

   localparam int c_tmax  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int c_tmr_w = $clog2(c_tmax + 1);
   localparam int c_dbc_w = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_tmr_w-1:0] c_delay_last  = c_tmr_w'(REPEAT_DELAY - 1);
   localparam logic [c_tmr_w-1:0] c_period_last = c_tmr_w'(REPEAT_PERIOD - 1);
   localparam logic [c_dbc_w-1:0] c_db_last     = c_dbc_w'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_HOLD_DELAY   = 2'd1,
      ST_HOLD_REPEAT  = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } state_t;

   // Bit order for all per-button vectors: 0 = up, 1 = down, 2 = load.
   logic [2:0] w_raw;
   logic [2:0] r_sync1;
   logic [2:0] r_sync2;
   logic [2:0] w_db;

   assign w_raw = {btn_load, btn_down, btn_up};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_db
      logic                r_level;
      logic [c_dbc_w-1:0]  r_cnt;

      always_ff @(posedge clock) begin
         if (reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
         end else if (r_sync2[gi] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_db_last) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign w_db[gi] = r_level;
   end

   state_t               r_state;
   logic                 r_dir;     // 0 = up, 1 = down
   logic [c_tmr_w-1:0]   r_timer;
   logic                 w_active;
   logic                 w_abort;
   logic [c_tmr_w-1:0]   w_last;

   assign w_active = r_dir ? w_db[1] : w_db[0];
   assign w_abort  = (r_dir ? w_db[0] : w_db[1]) | w_db[2];
   assign w_last   = (r_state == ST_HOLD_DELAY) ? c_delay_last : c_period_last;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_dir      <= 1'b0;
         r_timer    <= '0;
         up_pulse   <= 1'b0;
         down_pulse <= 1'b0;
         load_pulse <= 1'b0;
         held       <= 1'b0;
      end else begin
         up_pulse   <= 1'b0;
         down_pulse <= 1'b0;
         load_pulse <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_db[2]) begin
                  load_pulse <= 1'b1;
                  r_state    <= ST_WAIT_RELEASE;
               end else if (w_db[0] && !w_db[1]) begin
                  up_pulse <= 1'b1;
                  r_dir    <= 1'b0;
                  r_timer  <= '0;
                  r_state  <= ST_HOLD_DELAY;
                  held     <= 1'b1;
               end else if (w_db[1] && !w_db[0]) begin
                  down_pulse <= 1'b1;
                  r_dir      <= 1'b1;
                  r_timer    <= '0;
                  r_state    <= ST_HOLD_DELAY;
                  held       <= 1'b1;
               end else if (w_db[0] && w_db[1]) begin
                  r_state <= ST_WAIT_RELEASE;
               end
            end
            ST_HOLD_DELAY, ST_HOLD_REPEAT: begin
               if (!w_active) begin
                  r_state <= ST_IDLE;
                  held    <= 1'b0;
               end else if (w_abort) begin
                  // A load arriving mid-hold is swallowed, not issued.
                  r_state <= ST_WAIT_RELEASE;
                  held    <= 1'b0;
               end else if (repeat_en) begin
                  if (r_timer == w_last) begin
                     up_pulse   <= ~r_dir;
                     down_pulse <= r_dir;
                     r_timer    <= '0;
                     r_state    <= ST_HOLD_REPEAT;
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
            end
            ST_WAIT_RELEASE: begin
               if (w_db == 3'b000) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               held    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_updown_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_updown_pulse_gen: directed scenarios plus random button traffic.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_updown_pulse_gen;

   localparam int D  = 4;
   localparam int RD = 8;
   localparam int RP = 3;

   logic clock = 1'b0;
   logic reset;
   logic btn_up, btn_down, btn_load, repeat_en;
   logic up_pulse, down_pulse, load_pulse, held;

   updown_pulse_gen #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_load   (btn_load),
      .repeat_en  (repeat_en),
      .up_pulse   (up_pulse),
      .down_pulse (down_pulse),
      .load_pulse (load_pulse),
      .held       (held)
   );

   always #5 clock = ~clock;

   // Reference model: raw -> two-stage delay -> "last D samples all differ"
   // debounce -> press/hold/blocked modes with a held-age counter.
   localparam int M_IDLE  = 0;
   localparam int M_HOLD  = 1;
   localparam int M_BLOCK = 2;

   int  cyc = 0;
   bit  ms1 [3];
   bit  ms2 [3];
   bit  mdb [3];
   bit  mhist [3][$];
   int  mode = M_IDLE;
   int  mdir = 0;
   int  mage = 0;
   bit  e_up, e_down, e_load, e_held;

   always @(posedge clock) begin
      bit raw [3];
      bit p_up, p_down, p_load;
      cyc++;
      raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_load;
      p_up = 0; p_down = 0; p_load = 0;
      if (reset) begin
         for (int b = 0; b < 3; b++) begin
            ms1[b] = 0; ms2[b] = 0; mdb[b] = 0; mhist[b].delete();
         end
         mode = M_IDLE; mage = 0;
      end else begin
         case (mode)
            M_IDLE: begin
               if (mdb[2]) begin p_load = 1; mode = M_BLOCK; end
               else if (mdb[0] && !mdb[1]) begin p_up = 1; mdir = 0; mage = 0; mode = M_HOLD; end
               else if (mdb[1] && !mdb[0]) begin p_down = 1; mdir = 1; mage = 0; mode = M_HOLD; end
               else if (mdb[0] && mdb[1]) mode = M_BLOCK;
            end
            M_HOLD: begin
               if (!mdb[mdir]) mode = M_IDLE;
               else if (mdb[1 - mdir] || mdb[2]) mode = M_BLOCK;
               else if (repeat_en) begin
                  mage++;
                  if (mage == RD || (mage > RD && (mage - RD) % RP == 0)) begin
                     if (mdir == 0) p_up = 1; else p_down = 1;
                  end
               end
            end
            default: if (!mdb[0] && !mdb[1] && !mdb[2]) mode = M_IDLE;
         endcase
         for (int b = 0; b < 3; b++) begin
            bit all_diff;
            mhist[b].push_back(ms2[b]);
            if (mhist[b].size() > D) void'(mhist[b].pop_front());
            all_diff = (mhist[b].size() == D);
            for (int k = 0; k < mhist[b].size(); k++)
               if (mhist[b][k] == mdb[b]) all_diff = 0;
            if (all_diff) begin
               mdb[b] = ~mdb[b];
               mhist[b].delete();
            end
            ms2[b] = ms1[b];
            ms1[b] = raw[b];
         end
      end
      e_up = p_up; e_down = p_down; e_load = p_load;
      e_held = (mode == M_HOLD);
   end

   int total = 0;
   int bad   = 0;
   int up_q[$], down_q[$], load_q[$];

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d (cyc=%0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         total++;
         if ({up_pulse, down_pulse, load_pulse, held} !== {e_up, e_down, e_load, e_held}) begin
            bad++;
            $display("FAIL model cyc=%0d got=%b want=%b", cyc,
                     {up_pulse, down_pulse, load_pulse, held}, {e_up, e_down, e_load, e_held});
         end
         total++;
         if ($countones({up_pulse, down_pulse, load_pulse}) > 1) begin
            bad++;
            $display("FAIL exclusive cyc=%0d got=%b want=at most one", cyc,
                     {up_pulse, down_pulse, load_pulse});
         end
         if (up_pulse === 1'b1)   up_q.push_back(cyc);
         if (down_pulse === 1'b1) down_q.push_back(cyc);
         if (load_pulse === 1'b1) load_q.push_back(cyc);
      end
   endtask

   task automatic clear_q();
      up_q.delete(); down_q.delete(); load_q.delete();
   endtask

   function automatic int first(input int q[$]);
      return (q.size() > 0) ? q[0] : -1;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, r;
      int seq [6];
      reset = 1; btn_up = 0; btn_down = 0; btn_load = 0; repeat_en = 0;
      step(3);
      check("reset_outs", {28'd0, up_pulse, down_pulse, load_pulse, held}, 0);
      reset = 0;
      step(3);

      // Clean press of 5 cycles: one pulse D+2 edges after first sample.
      repeat_en = 1; clear_q();
      btn_up = 1; t = cyc + 1;
      step(5); btn_up = 0;
      step(2);
      check("clean_held", int'(held), 1);
      step(18);
      check("clean_cnt", up_q.size(), 1);
      check("clean_lat", first(up_q) - t, 6);
      check("clean_held_end", int'(held), 0);

      // Bounce rejection.
      repeat_en = 0; clear_q();
      seq = '{1, 0, 1, 1, 0, 1};
      for (int i = 0; i < 6; i++) begin
         btn_down = seq[i][0];
         if (i == 5) t = cyc + 1;
         step(1);
      end
      step(14);
      check("bounce_cnt", down_q.size(), 1);
      check("bounce_lat", first(down_q) - t, 6);
      btn_down = 0; step(15);

      // Auto-repeat over a 30-cycle hold.
      repeat_en = 1; clear_q();
      btn_up = 1; t = cyc + 1;
      step(30); btn_up = 0; step(15);
      check("rep_cnt", up_q.size(), 9);
      check("rep_gap1", (up_q.size() > 1) ? up_q[1] - up_q[0] : -1, 8);
      check("rep_gap2", (up_q.size() > 2) ? up_q[2] - up_q[1] : -1, 3);
      check("rep_last", (up_q.size() > 0) ? up_q[up_q.size() - 1] - t : -1, 35);

      // Load beats a simultaneous up.
      clear_q();
      btn_up = 1; btn_load = 1; t = cyc + 1;
      step(20);
      check("load_cnt", load_q.size(), 1);
      check("load_lat", first(load_q) - t, 6);
      check("load_no_up", up_q.size(), 0);
      btn_up = 0; btn_load = 0; step(15);
      check("load_quiet", up_q.size() + down_q.size() + load_q.size(), 1);

      // Conflict during repeat, then a normal press.
      repeat_en = 1; clear_q();
      btn_down = 1; t = cyc + 1;
      step(20); btn_up = 1; step(15);
      check("conf_down", down_q.size(), 5);
      check("conf_up", up_q.size(), 0);
      btn_up = 0; btn_down = 0; step(15);
      check("conf_quiet", up_q.size() + down_q.size(), 5);
      repeat_en = 0; clear_q();
      btn_up = 1; t = cyc + 1;
      step(10); btn_up = 0; step(15);
      check("conf_next_lat", first(up_q) - t, 6);

      // Reset in the middle of a repeating hold.
      repeat_en = 1; clear_q();
      btn_up = 1;
      step(20);
      reset = 1; step(1);
      check("rst_mid_outs", {28'd0, up_pulse, down_pulse, load_pulse, held}, 0);
      reset = 0; r = cyc; clear_q();
      step(12);
      check("rst_mid_cnt", up_q.size(), 1);
      check("rst_mid_lat", first(up_q) - r, 7);
      btn_up = 0; step(15);

      // Random traffic.
      for (int n = 0; n < 250; n++) begin
         btn_up    = ($urandom_range(0, 1) == 1);
         btn_down  = ($urandom_range(0, 2) == 0);
         btn_load  = ($urandom_range(0, 5) == 0);
         repeat_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 39) == 0) begin
            reset = 1; step(1); reset = 0;
         end
         step(($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8));
      end
      btn_up = 0; btn_down = 0; btn_load = 0;
      step(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/updown_pulse_gen.md
Name: updown_pulse_gen

Overview:
- Upstream front-end for the parametric up/down counter.
- Converts three raw, bouncy, asynchronous push-button inputs (up, down, load) into clean single-cycle control pulses for the counter's up/down/reset inputs.
- Includes per-button synchronisation, debouncing and hold-to-auto-repeat.
- Output pulses are registered, mutually exclusive and at most one per cycle.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples needed to change a debounced level; legal range >= 1.
- REPEAT_DELAY, 64: cycles from the first pulse of a held up/down press to the first auto-repeat pulse; legal range >= 2.
- REPEAT_PERIOD, 16: cycles between subsequent auto-repeat pulses; legal range >= 1.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_up  input  1  raw up button, asynchronous, active-high.
- btn_down  input  1  raw down button, asynchronous, active-high.
- btn_load  input  1  raw load button, asynchronous, active-high.
- repeat_en  input  1  1 = auto-repeat enabled while up/down is held.
- up_pulse  output  1  one-cycle increment request; drives the counter's up input.
- down_pulse  output  1  one-cycle decrement request; drives the counter's down input.
- load_pulse  output  1  one-cycle load request; drives the counter's reset/load input.
- held  output  1  high while a single up/down press is being held (HOLD_DELAY or HOLD_REPEAT).

Behaviour:
- Reset: all flops clear on the next rising edge with reset=1.
  - Synchronisers and debounced levels go to 0.
  - Timers go to 0; FSM goes to IDLE.
  - up_pulse, down_pulse, load_pulse and held all go to 0.
- Reset asserted mid-hold aborts the hold. A button still held at reset release is treated as a new press (full latency applies).
- Synchroniser: two-flop chain per button.
- Debounce: one independent debouncer per button, each with a level db_x and a counter.
  - If the synchronised value differs from db_x, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while a difference is still present, db_x toggles and the counter clears.
  - Any sample equal to db_x clears the counter.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach db_x.
- Latency: raw input first sampled high at edge N, and stable afterwards, gives db high after edge N+DEBOUNCE_CYCLES+1. The pulse is then registered and visible after edge N+DEBOUNCE_CYCLES+2, lasting exactly one cycle.
- FSM states: IDLE, HOLD_DELAY, HOLD_REPEAT, WAIT_RELEASE. Pulse outputs are registered from the transition logic.
- IDLE:
  - db_load=1 -> load_pulse, go to WAIT_RELEASE. Load has highest priority, even with up/down also high.
  - Else db_up=1 and db_down=0 -> up_pulse, dir=UP, timer=0, go to HOLD_DELAY.
  - Else db_down=1 and db_up=0 -> down_pulse, dir=DOWN, timer=0, go to HOLD_DELAY.
  - Else db_up=1 and db_down=1 -> no pulse, go to WAIT_RELEASE.
- HOLD_DELAY:
  - Active button's db falls -> IDLE, no pulse.
  - Opposite button or load db rises -> WAIT_RELEASE, no pulse. A load in this state is ignored, not issued.
  - repeat_en=1 and timer = REPEAT_DELAY-1 -> pulse in dir, timer=0, go to HOLD_REPEAT.
  - Otherwise timer increments if repeat_en=1 and holds if repeat_en=0.
- HOLD_REPEAT:
  - Same release and abort rules as HOLD_DELAY.
  - repeat_en=0 -> timer holds, no pulses.
  - Timer = REPEAT_PERIOD-1 -> pulse in dir, timer=0.
- WAIT_RELEASE: no pulses. Go to IDLE once db_up, db_down and db_load are all 0.
- held = 1 exactly when the state is HOLD_DELAY or HOLD_REPEAT (registered with the state).
- Timer width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1). The debounce counter width is derived the same way from DEBOUNCE_CYCLES. No wrap is possible: each counter clears at its terminal value.
- Invariant: up_pulse + down_pulse + load_pulse <= 1 in every cycle.

Test Plan:
- Clean press: D=4, RD=8, RP=3; btn_up high from edge 0 for 5 cycles, then low -> single up_pulse after edge 6; held goes high then low; no further pulses.
- Bounce rejection: D=4; btn_down toggles 1,0,1,1,0,1 (runs shorter than 4), then stays high -> no pulse during the bounce; exactly one down_pulse D+2 edges after the start of the final stable run.
- Auto-repeat: D=4, RD=8, RP=3, repeat_en=1; btn_up held for 30 cycles -> pulses at t0, t0+8, t0+11, t0+14, …; stop within D+2 cycles of release.
- Load priority: btn_up and btn_load rise together -> only load_pulse, exactly once; nothing more until all buttons are released.
- Conflict: btn_down held into HOLD_REPEAT, then btn_up pressed -> no further pulses of either kind until both are released; next clean press works normally.
- Reset mid-hold: reset=1 for 1 cycle in HOLD_REPEAT with btn_up held -> all outputs 0 next cycle; a fresh up_pulse appears D+2 edges after reset deasserts.
